sha256_multiblock_core: RTL

//  Parametrised SHA-256 engine for fixed-length messages of any size. Pads internally and

---
 rtl/sha256_multiblock_core.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_multiblock_core.sv
// sha256_multiblock_core
//   SHA-256 engine for fixed-length messages of MSG_BITS bits. The message is
//   padded internally and NB = ceil((MSG_BITS+65)/512) blocks are compressed,
//   one round per clock. The full digest is held on H_out until the next
//   block update.
//
// Ports
//   clk        in   1         rising-edge clock
//   reset      in   1         synchronous, active-low reset
//   in_valid   in   1         message valid
//   in_ready   out  1         core idle; message taken on in_valid && in_ready
//   message    in   MSG_BITS  message, first byte in message[MSG_BITS-1 -: 8]
//   out_valid  out  1         digest valid, held until accepted
//   out_ready  in   1         digest taken on out_valid && out_ready
//   H_out      out  256       digest, H0 in [255:224]
//   busy       out  1         hashing (LOAD/ROUND/UPDATE)
//   mode224    in   1         only with SHA256_MODE224_EN: SHA-224 IVs and
//                             truncated digest, sampled at the input handshake
//
// Build option: define SHA256_MODE224_EN to add the mode224 port.
//
// state  | meaning
// IDLE   | waiting for a message, in_ready high
// LOAD   | fill W ring with block blk, copy H into working vars
// ROUND  | one compression round per cycle, rnd = 0..63
// UPDATE | fold working vars into H, next block or finish
// DONE   | digest presented, waiting for out_ready

module sha256_multiblock_core #(
    parameter int MSG_BITS = 96
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MSG_BITS-1:0] message,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [255:0]        H_out,
    output logic                busy
`ifdef SHA256_MODE224_EN
    ,
    input  logic                mode224
`endif
);

    localparam int NB        = (MSG_BITS + 65 + 511) / 512;
    localparam int PAD_BITS  = NB * 512;
    localparam int ZERO_BITS = PAD_BITS - MSG_BITS - 65;
    localparam int BLK_W     = $clog2(NB + 1);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_DONE
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t               state_q, state_d;
    logic [MSG_BITS-1:0]  msg_q;
    logic [31:0]          h_q [8];
    logic [31:0]          v_q [8];
    logic [31:0]          w_q [16];
    logic [5:0]           rnd_q;
    logic [BLK_W-1:0]     blk_q;
    logic                 m224_q;
    logic [255:0]         h_out_q;

    logic                 mode_in;
    logic                 last_blk;
    logic [PAD_BITS-1:0]  padded;
    logic [511:0]         blk_data;
    logic [3:0]           ri;
    logic [31:0]          w_exp, w_t, t1, t2;
    logic [31:0]          h_sum [8];
    logic [255:0]         digest_next;

`ifdef SHA256_MODE224_EN
    assign mode_in = mode224;
`else
    assign mode_in = 1'b0;
`endif

    assign last_blk = (blk_q == BLK_W'(NB - 1));

    // Block 0 sits in the top 512 bits of the padded message.
    assign padded   = {msg_q, 1'b1, {ZERO_BITS{1'b0}}, 64'(MSG_BITS)};
    assign blk_data = padded[(NB - 1 - int'(blk_q)) * 512 +: 512];

    // W ring: slot rnd mod 16 still holds W[rnd-16] when rnd >= 16, and is
    // overwritten with W[rnd] in the same cycle it is consumed.
    assign ri    = rnd_q[3:0];
    assign w_exp = ssig1(w_q[ri - 4'd2]) + w_q[ri - 4'd7]
                 + ssig0(w_q[ri - 4'd15]) + w_q[ri];
    assign w_t   = (rnd_q[5:4] == 2'b00) ? w_q[ri] : w_exp;

    assign t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
              + K[rnd_q] + w_t;
    assign t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = h_q[i] + v_q[i];
        end
    end

    // SHA-224 drops H7 from the published digest.
    assign digest_next = {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                          h_sum[4], h_sum[5], h_sum[6],
                          m224_q ? 32'h0 : h_sum[7]};

    assign H_out = h_out_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                busy = 1'b1;
                if (rnd_q == 6'd63) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                busy    = 1'b1;
                state_d = last_blk ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            msg_q   <= '0;
            m224_q  <= 1'b0;
            rnd_q   <= '0;
            blk_q   <= '0;
            h_out_q <= '0;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= '0;
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        msg_q  <= message;
                        m224_q <= mode_in;
                        blk_q  <= '0;
                        for (int i = 0; i < 8; i++) begin
                            h_q[i] <= mode_in ? IV224[i] : IV256[i];
                        end
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < 16; i++) begin
                        w_q[i] <= blk_data[511 - 32 * i -: 32];
                    end
                    for (int i = 0; i < 8; i++) begin
                        v_q[i] <= h_q[i];
                    end
                    rnd_q <= '0;
                end
                S_ROUND: begin
                    w_q[ri] <= w_t;
                    v_q[7]  <= v_q[6];
                    v_q[6]  <= v_q[5];
                    v_q[5]  <= v_q[4];
                    v_q[4]  <= v_q[3] + t1;
                    v_q[3]  <= v_q[2];
                    v_q[2]  <= v_q[1];
                    v_q[1]  <= v_q[0];
                    v_q[0]  <= t1 + t2;
                    rnd_q   <= rnd_q + 6'd1;
                end
                S_UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        h_q[i] <= h_sum[i];
                    end
                    h_out_q <= digest_next;
                    if (!last_blk) begin
                        blk_q <= blk_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
